// File: rtl/debounce_sync.sv
// -----------------------------------------------------------------------------
// debounce_sync
//   Conditions a raw asynchronous input such as a push-button or a switch.
//   The input passes through a flop synchroniser. A stability counter and a
//   4-state FSM then filter out bounce. The block produces a clean level and
//   single-cycle edge pulses. d_out feeds the D input of the downstream d_ff
//   stage directly.
//
// Parameters
//   SYNC_STAGES     synchroniser depth on din (>= 2)
//   DEBOUNCE_CYCLES consecutive equal synchronised samples needed to accept a
//                   new level (>= 2)
//   CNT_W           stability counter width (derived; do not override)
//
// Ports
//   clk    in   system clock; all state updates on posedge
//   reset  in   asynchronous, active-low reset (0 = reset asserted)
//   din    in   raw asynchronous input, may bounce
//   d_out  out  debounced, synchronised level
//   rise   out  one-cycle pulse when d_out goes 0->1
//   fall   out  one-cycle pulse when d_out goes 1->0
//   busy   out  high while a candidate level change is being qualified
// -----------------------------------------------------------------------------
module debounce_sync #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES) + 1
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic d_out,
  output logic rise,
  output logic fall,
  output logic busy
);

  typedef enum logic [1:0] {
    IDLE_LOW,
    WAIT_HIGH,
    IDLE_HIGH,
    WAIT_LOW
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [CNT_W-1:0]       r_cnt;
  state_t                 r_state;
  logic                   w_s;

  // The FSM sees only the last synchroniser flop, never din itself.
  assign w_s = r_sync[SYNC_STAGES-1];

  // NOTE: sequential state uses non-blocking (<=) so that every flop samples
  // pre-edge values; blocking here would collapse the synchroniser chain.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], din};
    end
  end

  // A single FSM block owns the counter and all outputs, so every output is
  // a flop. rise and fall default low each cycle, which makes them
  // one-cycle pulses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE_LOW;
      r_cnt   <= '0;
      d_out   <= 1'b0;
      rise    <= 1'b0;
      fall    <= 1'b0;
      busy    <= 1'b0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      unique case (r_state)
        IDLE_LOW: begin
          if (w_s) begin
            r_state <= WAIT_HIGH;
            r_cnt   <= CNT_ONE;
            busy    <= 1'b1;
          end
        end
        WAIT_HIGH: begin
          // The abort is tested first, so a drop that coincides with the
          // final count still rejects the candidate.
          if (!w_s) begin
            r_state <= IDLE_LOW;
            r_cnt   <= '0;
            busy    <= 1'b0;
          end else if (r_cnt == CNT_LAST) begin
            r_state <= IDLE_HIGH;
            r_cnt   <= '0;
            d_out   <= 1'b1;
            rise    <= 1'b1;
            busy    <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        IDLE_HIGH: begin
          if (!w_s) begin
            r_state <= WAIT_LOW;
            r_cnt   <= CNT_ONE;
            busy    <= 1'b1;
          end
        end
        WAIT_LOW: begin
          if (w_s) begin
            r_state <= IDLE_HIGH;
            r_cnt   <= '0;
            busy    <= 1'b0;
          end else if (r_cnt == CNT_LAST) begin
            r_state <= IDLE_LOW;
            r_cnt   <= '0;
            d_out   <= 1'b0;
            fall    <= 1'b1;
            busy    <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= IDLE_LOW;
          r_cnt   <= '0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_debounce_sync.sv
// -----------------------------------------------------------------------------
// tb_debounce_sync
//   Directed bench for debounce_sync with SYNC_STAGES=2 and DEBOUNCE_CYCLES=4.
//   Edges are numbered from the first posedge after din changes. A steady
//   change makes busy rise after edge 3. It makes d_out change, together with
//   its pulse, after edge 6. The pulse clears after edge 7.
// -----------------------------------------------------------------------------
module tb_debounce_sync;

  logic clk;
  logic reset;
  logic din;
  logic d_out;
  logic rise;
  logic fall;
  logic busy;

  int checks = 0;
  int errors = 0;

  debounce_sync #(
    .SYNC_STAGES    (2),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .din  (din),
    .d_out(d_out),
    .rise (rise),
    .fall (fall),
    .busy (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic expect_outs(input string tag, input logic e_d, input logic e_r,
                             input logic e_f, input logic e_b);
    check({tag, ".d_out"}, d_out, e_d);
    check({tag, ".rise"},  rise,  e_r);
    check({tag, ".fall"},  fall,  e_f);
    check({tag, ".busy"},  busy,  e_b);
  endtask

  // Sample 1 time unit after the active edge; inputs are also driven here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Row n gives the outputs expected after edge n+1 for a steady change.
  // Columns are d_out, rise, fall, busy.
  typedef logic [3:0] vec_t;
  localparam vec_t UP_SEQ [7] = '{4'b0000, 4'b0000, 4'b0001, 4'b0001,
                                  4'b0001, 4'b1100, 4'b1000};
  localparam vec_t DN_SEQ [7] = '{4'b1000, 4'b1000, 4'b1001, 4'b1001,
                                  4'b1001, 4'b0010, 4'b0000};

  task automatic run_seq(input string tag, input logic up);
    vec_t v;
    for (int i = 0; i < 7; i++) begin
      tick();
      v = up ? UP_SEQ[i] : DN_SEQ[i];
      expect_outs($sformatf("%s.e%0d", tag, i + 1), v[3], v[2], v[1], v[0]);
    end
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1. reset held for 3 cycles, then released with din=0
    reset = 1'b0;
    din   = 1'b0;
    #1;
    expect_outs("rst.async", 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_outs($sformatf("rst.hold%0d", i), 1'b0, 1'b0, 1'b0, 1'b0);
    end
    reset = 1'b1;
    tick();
    expect_outs("rst.rel", 1'b0, 1'b0, 1'b0, 1'b0);

    // 2. clean rise
    din = 1'b1;
    run_seq("rise", 1'b1);

    // 4. clean fall from d_out=1
    din = 1'b0;
    run_seq("fall", 1'b0);

    // 3. bounce: edges 1-2 sample 1, edge 3 samples 0, then 1 steady.
    // s=1 at edges 3,4, s=0 at edge 5, s=1 from edge 6. Acceptance is at edge 9.
    din = 1'b1;
    for (int e = 1; e <= 10; e++) begin
      tick();
      if (e == 2) din = 1'b0;
      if (e == 3) din = 1'b1;
      if (e == 3 || e == 4 || e == 6 || e == 7 || e == 8)
        expect_outs($sformatf("bnc.e%0d", e), 1'b0, 1'b0, 1'b0, 1'b1);
      else if (e == 9)
        expect_outs("bnc.e9", 1'b1, 1'b1, 1'b0, 1'b0);
      else if (e == 10)
        expect_outs("bnc.e10", 1'b1, 1'b0, 1'b0, 1'b0);
      else
        expect_outs($sformatf("bnc.e%0d", e), 1'b0, 1'b0, 1'b0, 1'b0);
    end
    din = 1'b0;
    run_seq("fall2", 1'b0);

    // 5. reset mid-cycle in WAIT_HIGH with cnt=2 (after edge 4)
    din = 1'b1;
    for (int e = 1; e <= 4; e++) tick();
    check("mr.busy_pre", busy, 1'b1);
    #2 reset = 1'b0;
    #1 expect_outs("mr.async", 1'b0, 1'b0, 1'b0, 1'b0);
    #1 reset = 1'b1;
    // Qualification restarts from an empty synchroniser and cnt=0.
    run_seq("mr.restart", 1'b1);
    din = 1'b0;
    run_seq("fall3", 1'b0);

    // 6. 3-cycle glitch: s=1 at edges 3-5, so busy is high after edges 3-5.
    // The abort at edge 6 coincides with cnt reaching its last value.
    din = 1'b1;
    for (int e = 1; e <= 10; e++) begin
      tick();
      if (e == 3) din = 1'b0;
      expect_outs($sformatf("gl.e%0d", e), 1'b0, 1'b0, 1'b0,
                  (e >= 3 && e <= 5) ? 1'b1 : 1'b0);
    end

    // din stuck low: the FSM stays idle and produces no pulses.
    for (int e = 1; e <= 12; e++) begin
      tick();
      expect_outs($sformatf("stuck.e%0d", e), 1'b0, 1'b0, 1'b0, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
